// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned FIFO_DEPTH = 4;

    // Cycles allowed between falling edges inside a frame.
    function automatic int unsigned timeout_cyc(input int unsigned clk_hz,
                                                input int unsigned timeout_us);
        return (clk_hz / 1_000_000) * timeout_us;
    endfunction

endpackage

// File: rtl/ps2_fifo4.sv
// Four-entry first-word-fall-through byte FIFO with sticky overflow flag.
module ps2_fifo4
    import ps2_rx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] rd_data_o,
    output logic       empty_o,
    output logic       overflow_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            full, do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == CntW'(FIFO_DEPTH));
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign overflow_o = ovf_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop_i & ~empty_o;
        // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
        do_push  = push_i & (~full | do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        ovf_d   = ovf_q | (push_i & ~do_push);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronise and filter the pins, frame 11-bit packets,
// check parity/stop, recover from stalled frames and queue good bytes.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rd_data,
    output logic       empty,
    input  logic       rd_en,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);
    localparam int unsigned TimeoutCyc = timeout_cyc(CLK_HZ, TIMEOUT_US);
    localparam int unsigned TmoW       = $clog2(TimeoutCyc + 1);
    localparam int unsigned FiltW      = $clog2(FILTER_LEN + 1);

    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             fclk_q, fclk_d;
    logic             fclk_prev_q, fclk_prev_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             push_q, push_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             fall, data_bit, frame_odd;

    assign fall       = fclk_prev_q & ~fclk_q;
    assign data_bit   = data_sync_q[1];
    assign frame_odd  = ^{shift_q, parity_q};
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        fclk_prev_d = fclk_q;
        fclk_d      = fclk_q;
        filt_cnt_d  = '0;
        if (clk_sync_q[1] != fclk_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                fclk_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FiltW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        push_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        case (state_q)
            StIdle: begin
                if (fall && !data_bit) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    parity_d = data_bit;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (data_bit && frame_odd) begin
                        push_d = 1'b1;
                    end else if (!frame_odd) begin
                        perr_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Stalled frame: abandon it and report a framing error.
        if (state_q != StIdle && !fall && tmo_q == TmoW'(TimeoutCyc - 1)) begin
            state_d = StIdle;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_prev_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    ps2_fifo4 u_fifo (
        .clk_i       (clk50),
        .rst_ni      (reset_n),
        .push_i      (push_q),
        .push_data_i (shift_q),
        .pop_i       (rd_en),
        .rd_data_o   (rd_data),
        .empty_o     (empty),
        .overflow_o  (overflow)
    );

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx using a scaled clock so the timeout is 200 cycles.
module tb_ps2_rx;
    localparam int unsigned Half = 20;

    logic       clk50    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en    = 1'b0;
    logic [7:0] rd_data;
    logic       empty, parity_err, frame_err, overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int p0, f0, w;

    always #5 clk50 = ~clk50;

    ps2_rx #(
        .CLK_HZ     (1_000_000),
        .FILTER_LEN (8),
        .TIMEOUT_US (200)
    ) dut (
        .clk50      (clk50),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_data    (rd_data),
        .empty      (empty),
        .rd_en      (rd_en),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    // Counts high cycles, so a stuck pulse shows up as an excess count.
    always @(negedge clk50) begin
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(Half);
        ps2_clk = 1'b0;
        cyc(Half);
        ps2_clk = 1'b1;
    endtask

    task automatic glitch();
        cyc(15);
        ps2_clk = 1'b0;
        cyc(5);
        ps2_clk = 1'b1;
        cyc(15);
    endtask

    // Sends the first nbits of a frame; glitch_at inserts a short clock dip before that bit.
    task automatic send(input logic [7:0] b, input logic par_flip, input logic stop,
                        input int nbits, input int glitch_at);
        logic [10:0] f;
        f = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_at) glitch();
            ps2_bit(f[i]);
        end
        ps2_data = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_rd_data", {24'd0, rd_data}, 32'h00);
        chk("rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        reset_n = 1'b1;
        cyc(5);

        // Good frame, then pop.
        send(8'h1C, 1'b0, 1'b1, 11, -1);
        cyc(5);
        chk("good_empty", {31'd0, empty}, 32'd0);
        chk("good_data", {24'd0, rd_data}, 32'h1C);
        pop();
        chk("pop_empty", {31'd0, empty}, 32'd1);

        // Bad parity, then a good frame.
        p0 = perr_cnt;
        f0 = ferr_cnt;
        send(8'h1C, 1'b1, 1'b1, 11, -1);
        cyc(5);
        chk("par_pulse", p0 + 1, perr_cnt);
        chk("par_no_ferr", f0, ferr_cnt);
        chk("par_empty", {31'd0, empty}, 32'd1);
        send(8'hF0, 1'b0, 1'b1, 11, -1);
        cyc(5);
        chk("f0_data", {24'd0, rd_data}, 32'hF0);
        pop();

        // Bad stop bit.
        p0 = perr_cnt;
        f0 = ferr_cnt;
        send(8'h5A, 1'b0, 1'b0, 11, -1);
        cyc(5);
        chk("stop_ferr", f0 + 1, ferr_cnt);
        chk("stop_no_perr", p0, perr_cnt);
        chk("stop_empty", {31'd0, empty}, 32'd1);

        // Abort after five data bits; the frame times out 200 cycles after the last fall.
        f0 = ferr_cnt;
        send(8'hA5, 1'b0, 1'b1, 6, -1);
        w = 0;
        while (!frame_err && w < 400) begin
            cyc(1);
            w++;
        end
        chk("tmo_seen", {31'd0, frame_err}, 32'd1);
        chk("tmo_latency", {31'd0, (w >= 189 && w <= 193)}, 32'd1);
        cyc(5);
        chk("tmo_one_pulse", f0 + 1, ferr_cnt);
        chk("tmo_empty", {31'd0, empty}, 32'd1);
        send(8'h12, 1'b0, 1'b1, 11, -1);
        cyc(5);
        chk("after_tmo_data", {24'd0, rd_data}, 32'h12);
        pop();

        // Fill beyond capacity.
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b0, 1'b1, 11, -1);
        end
        cyc(5);
        chk("full_head", {24'd0, rd_data}, 32'h01);
        chk("ovf_set", {31'd0, overflow}, 32'd1);

        // Push of 0x06 coincides with a pop while full: both succeed.
        send(8'h06, 1'b0, 1'b1, 10, -1);
        ps2_data = 1'b1;
        cyc(Half);
        ps2_clk = 1'b0;
        cyc(11);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        cyc(Half - 12);
        ps2_clk = 1'b1;
        cyc(10);
        chk("pp_head", {24'd0, rd_data}, 32'h02);
        chk("pp_ovf", {31'd0, overflow}, 32'd1);
        pop();
        chk("pp_q1", {24'd0, rd_data}, 32'h03);
        pop();
        chk("pp_q2", {24'd0, rd_data}, 32'h04);
        pop();
        chk("pp_q3", {24'd0, rd_data}, 32'h06);
        chk("pp_q3_nonempty", {31'd0, empty}, 32'd0);
        pop();
        chk("pp_drained", {31'd0, empty}, 32'd1);

        // Short clock glitches in idle and mid-data are ignored.
        p0 = perr_cnt;
        f0 = ferr_cnt;
        glitch();
        send(8'h3C, 1'b0, 1'b1, 11, 4);
        cyc(5);
        chk("glitch_data", {24'd0, rd_data}, 32'h3C);
        chk("glitch_errs", {perr_cnt - p0, ferr_cnt - f0}, 32'd0);

        // Reset mid-frame with a byte queued and overflow set.
        send(8'h99, 1'b0, 1'b1, 5, -1);
        reset_n = 1'b0;
        cyc(3);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_data", {24'd0, rd_data}, 32'h00);
        chk("mid_rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        reset_n = 1'b1;
        cyc(20);
        p0 = perr_cnt;
        f0 = ferr_cnt;
        send(8'h77, 1'b0, 1'b1, 11, -1);
        cyc(5);
        chk("post_rst_data", {24'd0, rd_data}, 32'h77);
        chk("post_rst_errs", {perr_cnt - p0, ferr_cnt - f0}, 32'd0);
        pop();
        chk("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
